// File: rtl/mysystem_sdram_start_pkg.sv
// Shared types and constants for the SDRAM start/status sequencer.
package mysystem_sdram_start_pkg;

    // Word offset of the start/status PIO register.
    localparam logic [1:0] START_REG = 2'd0;

    typedef enum logic [2:0] {
        StIdle,
        StSet,
        StWait,
        StRdAddr,
        StRdSample,
        StClr,
        StFinish
    } state_e;

    typedef struct packed {
        logic        chipselect;
        logic        write_n;
        logic [1:0]  address;
        logic [31:0] writedata;
    } bus_t;

    // Bus drive for a given state. This is loaded into the output registers
    // together with the state, so the bus always matches the current state.
    function automatic bus_t bus_for(state_e st);
        bus_t b;
        b.chipselect = 1'b0;
        b.write_n    = 1'b1;
        b.address    = START_REG;
        b.writedata  = 32'h0;
        case (st)
            StSet: begin
                b.chipselect = 1'b1;
                b.write_n    = 1'b0;
                b.writedata  = 32'h1;
            end
            StClr: begin
                b.chipselect = 1'b1;
                b.write_n    = 1'b0;
            end
            default: ;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/mysystem_sdram_start_ctrl.sv
// Start/poll sequencer: writes a start flag to a PIO slave, polls the remote
// done bit with a fixed gap, clears the flag, and reports done or timeout.
module mysystem_sdram_start_ctrl
    import mysystem_sdram_start_pkg::*;
#(
    parameter int unsigned POLL_GAP  = 4,
    parameter int unsigned MAX_POLLS = 1024,
    parameter int unsigned DONE_BIT  = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        go,
    output logic [1:0]  avm_address,
    output logic        avm_chipselect,
    output logic        avm_write_n,
    output logic [31:0] avm_writedata,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic [15:0] poll_count
);

    localparam logic [7:0]  GAP_LAST  = 8'(POLL_GAP - 1);
    localparam logic [16:0] MAX_POLLS_W = 17'(MAX_POLLS);

    state_e      state_q;
    bus_t        bus_q;
    logic        busy_q;
    logic        done_q;
    logic        timeout_q;
    logic        success_q;
    logic [7:0]  gap_q;
    logic [15:0] poll_cnt_q;

    // Only DONE_BIT of the read data matters; the rest is intentionally ignored.
    logic unused_readdata;
    assign unused_readdata = ^avm_readdata;

    // Sequencer FSM; every output is registered alongside the state transition.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            bus_q      <= bus_for(StIdle);
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
            success_q  <= 1'b0;
            gap_q      <= '0;
            poll_cnt_q <= '0;
        end else begin
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (go) begin
                        state_q    <= StSet;
                        bus_q      <= bus_for(StSet);
                        busy_q     <= 1'b1;
                        success_q  <= 1'b0;
                        gap_q      <= '0;
                        poll_cnt_q <= '0;
                    end
                end
                StSet: begin
                    state_q <= StWait;
                    bus_q   <= bus_for(StWait);
                end
                StWait: begin
                    if (gap_q == GAP_LAST) begin
                        gap_q   <= '0;
                        state_q <= StRdAddr;
                        bus_q   <= bus_for(StRdAddr);
                    end else begin
                        gap_q <= gap_q + 8'd1;
                    end
                end
                StRdAddr: begin
                    state_q <= StRdSample;
                    bus_q   <= bus_for(StRdSample);
                end
                StRdSample: begin
                    if (poll_cnt_q != 16'hFFFF) begin
                        poll_cnt_q <= poll_cnt_q + 16'd1;
                    end
                    // A done flag on the last allowed poll still counts as success.
                    if (avm_readdata[DONE_BIT]) begin
                        success_q <= 1'b1;
                        state_q   <= StClr;
                        bus_q     <= bus_for(StClr);
                    end else if ({1'b0, poll_cnt_q} + 17'd1 == MAX_POLLS_W) begin
                        success_q <= 1'b0;
                        state_q   <= StClr;
                        bus_q     <= bus_for(StClr);
                    end else begin
                        state_q <= StWait;
                        bus_q   <= bus_for(StWait);
                    end
                end
                StClr: begin
                    state_q   <= StFinish;
                    bus_q     <= bus_for(StFinish);
                    busy_q    <= 1'b0;
                    done_q    <= success_q;
                    timeout_q <= ~success_q;
                end
                StFinish: begin
                    state_q <= StIdle;
                    bus_q   <= bus_for(StIdle);
                end
                default: begin
                    state_q <= StIdle;
                    bus_q   <= bus_for(StIdle);
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign avm_address    = bus_q.address;
    assign avm_chipselect = bus_q.chipselect;
    assign avm_write_n    = bus_q.write_n;
    assign avm_writedata  = bus_q.writedata;
    assign busy           = busy_q;
    assign done           = done_q;
    assign timeout        = timeout_q;
    assign poll_count     = poll_cnt_q;

endmodule

// File: tb/tb_mysystem_sdram_start_ctrl.sv
// Bench for the start/poll sequencer: table of poll scenarios plus hand-written
// corner sequences, with bus writes and done/timeout pulses checked against a
// queue of expected events.
module tb_mysystem_sdram_start_ctrl;
    import mysystem_sdram_start_pkg::*;

    localparam int unsigned GAP  = 4;
    localparam int unsigned MAXP = 5;
    localparam int          PER  = int'(GAP) + 2;

    localparam int EV_WR   = 0;
    localparam int EV_DONE = 1;
    localparam int EV_TMO  = 2;

    typedef struct {
        int          cyc;
        int          kind;
        logic [31:0] data;
    } ev_t;

    typedef struct {
        bit          sel;
        int          rise;
        logic [31:0] lo;
        logic [31:0] hi;
        int          polls;
        bit          is_done;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        go0 = 1'b0;
    logic        go1 = 1'b0;
    logic [31:0] rd = '0;

    logic [1:0]  a0, a1;
    logic        cs0, cs1, wn0, wn1, busy0, busy1, done0, done1, tmo0, tmo1;
    logic [31:0] wd0, wd1;
    logic [15:0] pc0, pc1;

    logic [1:0]  m_a;
    logic        m_cs, m_wn, m_busy, m_done, m_tmo;
    logic [31:0] m_wd;
    logic [15:0] m_pc;

    int          checks = 0;
    int          passes = 0;
    int          cyc = 0;
    bit          sel = 1'b0;
    bit          chk_busy = 1'b0;
    logic [63:0] go_mask = '0;
    int          rise = 0;
    logic [31:0] rd_lo = '0;
    logic [31:0] rd_hi = '0;
    bit          exp_busy [0:127];
    ev_t         exp_q [$];
    vec_t        vecs [7];

    mysystem_sdram_start_ctrl #(.POLL_GAP(GAP), .MAX_POLLS(MAXP), .DONE_BIT(0)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .go(go0),
        .avm_address(a0), .avm_chipselect(cs0), .avm_write_n(wn0),
        .avm_writedata(wd0), .avm_readdata(rd),
        .busy(busy0), .done(done0), .timeout(tmo0), .poll_count(pc0)
    );

    mysystem_sdram_start_ctrl #(.POLL_GAP(GAP), .MAX_POLLS(MAXP), .DONE_BIT(3)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .go(go1),
        .avm_address(a1), .avm_chipselect(cs1), .avm_write_n(wn1),
        .avm_writedata(wd1), .avm_readdata(rd),
        .busy(busy1), .done(done1), .timeout(tmo1), .poll_count(pc1)
    );

    always #5 clk = ~clk;

    always_comb begin
        if (sel) {m_a, m_cs, m_wn, m_wd, m_busy, m_done, m_tmo, m_pc} =
                 {a1, cs1, wn1, wd1, busy1, done1, tmo1, pc1};
        else     {m_a, m_cs, m_wn, m_wd, m_busy, m_done, m_tmo, m_pc} =
                 {a0, cs0, wn0, wd0, busy0, done0, tmo0, pc0};
    end

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    task automatic observe(input int kind, input logic [31:0] data, input logic [1:0] addr);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_event c%0d: got kind %0d data %0h, required none",
                     cyc, kind, data);
        end else begin
            e = exp_q.pop_front();
            check($sformatf("event_c%0d", cyc),
                  {38'd0, 16'(cyc), 8'(kind), data, addr},
                  {38'd0, 16'(e.cyc), 8'(e.kind), e.data, START_REG});
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (m_done && m_tmo) check($sformatf("done_and_timeout_c%0d", cyc), 96'd1, 96'd0);
        if (m_cs && !m_wn) observe(EV_WR, m_wd, m_a);
        if (m_done) observe(EV_DONE, 32'h0, START_REG);
        if (m_tmo) observe(EV_TMO, 32'h0, START_REG);
        if (chk_busy && cyc < 128)
            check($sformatf("busy_c%0d", cyc), 96'(m_busy), 96'(exp_busy[cyc]));
    endtask

    task automatic drive();
        logic g;
        g = (cyc < 64) ? go_mask[cyc] : 1'b0;
        go0 = !sel && g;
        go1 = sel && g;
        rd = (rise != 0 && cyc >= 1 + PER * rise) ? rd_hi : rd_lo;
    endtask

    task automatic push_run(input int base, input int n, input bit is_done);
        exp_q.push_back('{base + 1, EV_WR, 32'h1});
        exp_q.push_back('{base + PER * n + 2, EV_WR, 32'h0});
        exp_q.push_back('{base + PER * n + 3, is_done ? EV_DONE : EV_TMO, 32'h0});
        for (int c = base + 1; c <= base + PER * n + 2; c++) exp_busy[c] = 1'b1;
    endtask

    task automatic run(input bit s, input logic [63:0] mask, input int r,
                       input logic [31:0] lo, input logic [31:0] hi, input int end_cyc);
        sel      = s;
        go_mask  = mask;
        rise     = r;
        rd_lo    = lo;
        rd_hi    = hi;
        cyc      = 0;
        chk_busy = 1'b1;
        drive();
        while (cyc < end_cyc) begin
            step();
            drive();
        end
        chk_busy = 1'b0;
        check("queue_empty", 96'(exp_q.size()), 96'd0);
        exp_q.delete();
        for (int c = 0; c < 128; c++) exp_busy[c] = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1);
    end

    initial begin
        // sel, rise (0 = never), readdata before/after rise, polls, done-vs-timeout
        vecs[0] = '{1'b0, 1, 32'h0,         32'h1,         1, 1'b1};
        vecs[1] = '{1'b0, 3, 32'h0,         32'h1,         3, 1'b1};
        vecs[2] = '{1'b0, 0, 32'h0,         32'h0,         5, 1'b0};
        vecs[3] = '{1'b0, 0, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 5, 1'b0};
        vecs[4] = '{1'b0, 5, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 5, 1'b1};
        vecs[5] = '{1'b1, 1, 32'h0,         32'h8,         1, 1'b1};
        vecs[6] = '{1'b1, 0, 32'hFFFF_FFF7, 32'hFFFF_FFF7, 5, 1'b0};
        for (int c = 0; c < 128; c++) exp_busy[c] = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_state_dut0", 96'({cs0, wn0, a0, wd0, busy0, done0, tmo0, pc0}),
              96'({1'b0, 1'b1, 2'b0, 32'h0, 1'b0, 1'b0, 1'b0, 16'h0}));
        check("reset_state_dut1", 96'({cs1, wn1, a1, wd1, busy1, done1, tmo1, pc1}),
              96'({1'b0, 1'b1, 2'b0, 32'h0, 1'b0, 1'b0, 1'b0, 16'h0}));
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 7; i++) begin
            push_run(0, vecs[i].polls, vecs[i].is_done);
            run(vecs[i].sel, 64'h1, vecs[i].rise, vecs[i].lo, vecs[i].hi,
                PER * vecs[i].polls + 6);
            check($sformatf("poll_count_vec%0d", i), 96'(m_pc), 96'(vecs[i].polls));
        end

        // go pulsed during WAIT and during CLR must not start another sequence.
        push_run(0, 2, 1'b1);
        run(1'b0, (64'h1 << 0) | (64'h1 << 3) | (64'h1 << (PER * 2 + 2)), 2,
            32'h0, 32'h1, PER * 2 + 8);
        check("poll_count_go_ignored", 96'(m_pc), 96'd2);

        // go held high re-triggers from IDLE right after FINISH.
        push_run(0, 1, 1'b1);
        push_run(PER + 4, 1, 1'b1);
        run(1'b0, 64'h7FF, 1, 32'h0, 32'h1, PER + 4 + PER + 6);
        check("poll_count_retrigger", 96'(m_pc), 96'd1);

        // Reset during the second WAIT: no CLR write, everything back to reset values.
        sel     = 1'b0;
        go_mask = 64'h1;
        rise    = 0;
        rd_lo   = 32'h0;
        rd_hi   = 32'h0;
        cyc     = 0;
        exp_q.push_back('{1, EV_WR, 32'h1});
        drive();
        while (cyc < PER + 2) begin
            step();
            drive();
        end
        check("poll_count_before_reset", 96'(m_pc), 96'd1);
        reset_n = 1'b0;
        #1;
        check("async_reset_outputs", 96'({m_cs, m_wn, m_a, m_wd, m_busy, m_done, m_tmo, m_pc}),
              96'({1'b0, 1'b1, 2'b0, 32'h0, 1'b0, 1'b0, 1'b0, 16'h0}));
        step();
        step();
        reset_n = 1'b1;
        repeat (PER * 6) begin
            step();
            drive();
        end
        check("queue_empty_after_reset", 96'(exp_q.size()), 96'd0);
        exp_q.delete();

        // Normal sequence after reset.
        push_run(0, 1, 1'b1);
        run(1'b0, 64'h1, 1, 32'h0, 32'h1, PER + 6);
        check("poll_count_after_reset", 96'(m_pc), 96'd1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/mysystem_sdram_start_ctrl.md
MYSYSTEM_SDRAM_START_CTRL -- requirements
Module: mysystem_sdram_start_ctrl

Interface
REQ-001 SHALL have parameter POLL_GAP, default 4, idle cycles between status polls; legal range 1..255.
REQ-002 SHALL have parameter MAX_POLLS, default 1024, polls before a timeout is declared; legal range 1..65535.
REQ-003 SHALL have parameter DONE_BIT, default 0, readdata bit index that carries the remote done flag.
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all logic is rising-edge.
REQ-005 SHALL have port reset_n, input, 1 bit, asynchronous active-low reset.
REQ-006 SHALL have port go, input, 1 bit, start request, sampled only in IDLE.
REQ-007 SHALL have port avm_address, output, 2 bits, Avalon-MM word address to the start/status PIO slave.
REQ-008 SHALL have port avm_chipselect, output, 1 bit, slave select.
REQ-009 SHALL have port avm_write_n, output, 1 bit, active-low write strobe.
REQ-010 SHALL have port avm_writedata, output, 32 bits, write data.
REQ-011 SHALL have port avm_readdata, input, 32 bits, slave read data, valid one cycle after the address is presented, fixed latency, no waitrequest.
REQ-012 SHALL have port busy, output, 1 bit, high while a sequence is in progress.
REQ-013 SHALL have port done, output, 1 bit, one-cycle pulse on successful completion.
REQ-014 SHALL have port timeout, output, 1 bit, one-cycle pulse on poll exhaustion.
REQ-015 SHALL have port poll_count, output, 16 bits, polls used by the last or current sequence.

Function
REQ-016 SHALL implement FSM states IDLE, SET, WAIT, RD_ADDR, RD_SAMPLE, CLR, FINISH, with all bus outputs registered and decoded from state.
REQ-017 SHALL, in IDLE with go=1, move to SET next cycle; poll_count and gap counter cleared on that edge.
REQ-018 SHALL, in SET (1 cycle), drive chipselect=1, write_n=0, address=0, writedata=32'h1; then go to WAIT.
REQ-019 SHALL, in WAIT, stay exactly POLL_GAP cycles, bus idle (chipselect=0, write_n=1, address=0, writedata=0); then go to RD_ADDR.
REQ-020 SHALL, in RD_ADDR (1 cycle), drive address=0, chipselect=0, write_n=1; then go to RD_SAMPLE.
REQ-021 SHALL, in RD_SAMPLE, increment poll_count (saturating at 16'hFFFF), then branch: readdata[DONE_BIT]=1 -> CLR, success; else poll_count+1==MAX_POLLS -> CLR, timeout; else -> WAIT.
REQ-022 SHALL, in CLR (1 cycle), drive chipselect=1, write_n=0, address=0, writedata=0; then go to FINISH.
REQ-023 SHALL, in FINISH (1 cycle), pulse done (success) or timeout (exhaustion), never both; return to IDLE.
REQ-024 SHALL hold busy=1 in SET, WAIT, RD_ADDR, RD_SAMPLE, CLR and busy=0 in IDLE and FINISH.
REQ-025 SHALL ignore go in every state except IDLE; go held high re-triggers one cycle after FINISH.
REQ-026 SHALL treat avm_readdata bits other than DONE_BIT as don't-care.
REQ-027 SHALL hold poll_count stable from FINISH until the next accepted go.

Reset
REQ-028 SHALL, on reset_n=0 at any time including mid-sequence, asynchronously force IDLE, chipselect=0, write_n=1, address=0, writedata=0, busy=0, done=0, timeout=0, poll_count=0, counters=0.
REQ-029 SHALL not issue the CLR write when reset interrupts a sequence; remote slave clears via its own reset.

Structure
REQ-030 SHALL place the state enumeration and PIO register offset constant (START_REG=0) in shared package mysystem_sdram_start_pkg.
REQ-031 SHALL be a single module with no sub-modules; gap and poll counters are inline.

Verification
REQ-032 SHALL test immediate done: POLL_GAP=4, readdata[0]=1 always, go at cycle 0 -> write 1 at c1, read addr at c6, write 0 at c8, done pulse at c9, poll_count=1.
REQ-033 SHALL test delayed done: readdata[0] rises before 3rd sample -> three RD_SAMPLE visits, done pulse, poll_count=3, timeout never high.
REQ-034 SHALL test timeout: MAX_POLLS=5, readdata=0 -> exactly 5 reads, CLR write of 0 issued, timeout pulse once, done=0, poll_count=5.
REQ-035 SHALL test go ignored while busy: pulse go in WAIT and CLR -> no extra SET write, single done pulse.
REQ-036 SHALL test reset mid-WAIT: reset_n low 2 cycles -> outputs at reset values within same cycle, no CLR write, next go runs full sequence normally.
REQ-037 SHALL test irrelevant bits: readdata=32'hFFFF_FFFE with DONE_BIT=0 -> not done; DONE_BIT=3 with readdata=32'h8 -> done after first poll.
